// File: rtl/dcr_launch_sequencer_if.sv
// dcr_launch_sequencer_if
//   Bundles the host config/launch handshake, the gpu_top DCR/start/done pins
//   and the sequencer status signals into one interface.
//   Modports:
//     slave  - the sequencer (dcr_launch_sequencer)
//     master - the host/control side that drives config and launch and models gpu_top
//   Signals:
//     cfg_valid/cfg_ready/cfg_addr/cfg_data  config entry handshake
//     launch                                 single-cycle launch request
//     busy, fifo_count, kernel_done, timeout_err  status
//     dcr_address/dcr_data_out/dcr_write_enable   DCR write strobe to gpu_top
//     start (to gpu_top), done (from gpu_top)
interface dcr_launch_sequencer_if #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic              cfg_valid;
  logic              cfg_ready;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  logic              launch;
  logic              busy;
  logic [CNT_W-1:0]  fifo_count;
  logic [ADDR_W-1:0] dcr_address;
  logic [DATA_W-1:0] dcr_data_out;
  logic              dcr_write_enable;
  logic              start;
  logic              done;
  logic              kernel_done;
  logic              timeout_err;

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, launch, done,
    output cfg_ready, busy, fifo_count, dcr_address, dcr_data_out,
           dcr_write_enable, start, kernel_done, timeout_err
  );

  modport master (
    output cfg_valid, cfg_addr, cfg_data, launch, done,
    input  cfg_ready, busy, fifo_count, dcr_address, dcr_data_out,
           dcr_write_enable, start, kernel_done, timeout_err
  );
endinterface

// File: rtl/dcr_launch_sequencer.sv
// dcr_launch_sequencer
//   Buffers host (address,data) config writes in a FIFO, replays them as
//   one-cycle DCR write strobes into gpu_top on launch, then raises start and
//   holds it until gpu_top reports done, pulsing kernel_done on completion.
//   Ports:
//     clk    - rising-edge clock
//     reset  - asynchronous, active-low reset
//     bus    - dcr_launch_sequencer_if.slave (config handshake, launch,
//              DCR/start/done pins, busy/fifo_count/kernel_done/timeout_err)
//   Optional feature: define DCR_LAUNCH_TIMEOUT_EN to enable a done watchdog of
//   TIMEOUT_CYCLES cycles in WAIT_DONE that sets the sticky timeout_err flag.
module dcr_launch_sequencer #(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int WRITE_GAP      = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                    clk,
  input logic                    reset,
  dcr_launch_sequencer_if.slave  bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_GAP, S_START, S_WAIT_DONE, S_COMPLETE
  } state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
  logic [CNT_W-1:0]  r_count;
  logic [3:0]        r_gap_cnt;
  logic              r_we, r_start, r_kdone, r_busy;
  logic [ADDR_W-1:0] r_addr, w_load_addr;
  logic [DATA_W-1:0] r_data, w_load_data;
  logic              w_full, w_push, w_pop, w_more;

  assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push       = (r_state == S_IDLE) && bus.cfg_valid && !w_full;
  // The entry on the DCR pins is popped at the end of its WRITE cycle, so a
  // push (IDLE only) and a pop never share a cycle.
  assign w_pop        = (r_state == S_WRITE);
  assign w_more       = (r_count > CNT_W'(1));
  assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);

`ifdef DCR_LAUNCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_terr;
  logic            w_to_hit;

  assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= '0;
      r_terr   <= 1'b0;
    end else begin
      r_to_cnt <= (r_state == S_WAIT_DONE) ? r_to_cnt + TO_W'(1) : '0;
      if (r_state == S_IDLE && bus.launch)
        r_terr <= 1'b0;
      else if (r_state == S_WAIT_DONE && !bus.done && w_to_hit)
        r_terr <= 1'b1;
    end
  end
  assign bus.timeout_err = r_terr;
`else
  // TIMEOUT_CYCLES is never negative, so the flag is permanently low here.
  assign bus.timeout_err = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (bus.launch) w_next = (r_count != '0 || w_push) ? S_WRITE : S_START;
      S_WRITE:
        if (!w_more)             w_next = S_START;
        else if (WRITE_GAP != 0) w_next = S_GAP;
        else                     w_next = S_WRITE;
      S_GAP:
        if (r_gap_cnt == 4'(WRITE_GAP - 1)) w_next = S_WRITE;
      S_START:
        w_next = S_WAIT_DONE;
      S_WAIT_DONE:
        if (bus.done) w_next = S_COMPLETE;
`ifdef DCR_LAUNCH_TIMEOUT_EN
        else if (w_to_hit) w_next = S_IDLE;
`endif
      S_COMPLETE:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  // Entry shown during the next WRITE cycle: bypass the config pins when the
  // launching push lands in an empty FIFO, skip the entry being popped when
  // writes are back-to-back, otherwise the head.
  always_comb begin
    w_load_addr = r_fifo_addr[r_rd_ptr];
    w_load_data = r_fifo_data[r_rd_ptr];
    if (r_state == S_IDLE && r_count == '0) begin
      w_load_addr = bus.cfg_addr;
      w_load_data = bus.cfg_data;
    end else if (r_state == S_WRITE) begin
      w_load_addr = r_fifo_addr[w_rd_ptr_nxt];
      w_load_data = r_fifo_data[w_rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= bus.cfg_addr;
      r_fifo_data[r_wr_ptr] <= bus.cfg_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_gap_cnt <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_start   <= 1'b0;
      r_kdone   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;
      r_count   <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 4'd1 : 4'd0;
      r_we      <= (w_next == S_WRITE);
      if (w_next == S_WRITE) begin
        r_addr <= w_load_addr;
        r_data <= w_load_data;
      end
      r_start   <= (w_next == S_START) || (w_next == S_WAIT_DONE);
      r_kdone   <= (w_next == S_COMPLETE);
      r_busy    <= (w_next != S_IDLE);
    end
  end

  assign bus.cfg_ready        = (r_state == S_IDLE) && !w_full;
  assign bus.busy             = r_busy;
  assign bus.fifo_count       = r_count;
  assign bus.dcr_address      = r_addr;
  assign bus.dcr_data_out     = r_data;
  assign bus.dcr_write_enable = r_we;
  assign bus.start            = r_start;
  assign bus.kernel_done      = r_kdone;
endmodule

// File: tb/tb_dcr_launch_sequencer.sv
// Bench for dcr_launch_sequencer: two instances (WRITE_GAP=0 and WRITE_GAP=2)
// share the same stimulus; a timing model predicts every write strobe, start
// rise, kernel_done / timeout and busy fall per instance into an event queue,
// and per-instance monitors pop and compare whenever the DUT shows an event.
module tb_dcr_launch_sequencer;
  localparam int TO = 16;
`ifdef DCR_LAUNCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int K_WR = 0, K_ST = 1, K_KD = 2, K_TO = 3, K_ID = 4;

  typedef struct { logic [3:0] a; logic [7:0] d; } ent_t;
  typedef struct { int cyc; int kind; logic [3:0] a; logic [7:0] d; } ev_t;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       cfg_valid = 1'b0, launch = 1'b0, done = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;
  int         cyc = 0, checks = 0, errors = 0;
  logic       pst0 = 1'b0, pb0 = 1'b0, pst1 = 1'b0, pb1 = 1'b0;

  ent_t stage[$];
  ent_t pend[$];
  ev_t  ev0[$];
  ev_t  ev2[$];

  dcr_launch_sequencer_if #(.ADDR_W(4), .DATA_W(8), .FIFO_DEPTH(8)) if0 ();
  dcr_launch_sequencer_if #(.ADDR_W(4), .DATA_W(8), .FIFO_DEPTH(8)) if2 ();

  assign if0.cfg_valid = cfg_valid;  assign if2.cfg_valid = cfg_valid;
  assign if0.cfg_addr  = cfg_addr;   assign if2.cfg_addr  = cfg_addr;
  assign if0.cfg_data  = cfg_data;   assign if2.cfg_data  = cfg_data;
  assign if0.launch    = launch;     assign if2.launch    = launch;
  assign if0.done      = done;       assign if2.done      = done;

  dcr_launch_sequencer #(.ADDR_W(4), .DATA_W(8), .FIFO_DEPTH(8), .WRITE_GAP(0),
                         .TIMEOUT_CYCLES(TO)) u_dut0 (.clk(clk), .reset(rst_n), .bus(if0));
  dcr_launch_sequencer #(.ADDR_W(4), .DATA_W(8), .FIFO_DEPTH(8), .WRITE_GAP(2),
                         .TIMEOUT_CYCLES(TO)) u_dut2 (.clk(clk), .reset(rst_n), .bus(if2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic void put(input int d, input ev_t e);
    if (d == 0) ev0.push_back(e);
    else        ev2.push_back(e);
  endfunction

  // Timing model: launch in cycle n, gap g, done high from cycle dc onward.
  function automatic void plan(input int d, input int g, input int n, input int dc);
    int k, s, w;
    ev_t e;
    k = pend.size();
    for (int i = 0; i < k; i++) begin
      e.cyc = n + 1 + i * (g + 1); e.kind = K_WR; e.a = pend[i].a; e.d = pend[i].d;
      put(d, e);
    end
    s = (k == 0) ? n + 1 : n + 1 + (k - 1) * (g + 1) + 1;
    e.a = '0; e.d = '0;
    e.cyc = s; e.kind = K_ST; put(d, e);
    w = (dc > s + 1) ? dc : s + 1;          // cycle in which done is sampled
    if (TO_EN && w > s + TO) begin
      e.cyc = s + TO + 1; e.kind = K_TO; put(d, e);
    end else begin
      e.cyc = w + 1; e.kind = K_KD; put(d, e);
      e.cyc = w + 2; e.kind = K_ID; put(d, e);
    end
  endfunction

  task automatic mon(input int d, input int c, input logic we, input logic [3:0] a,
                     input logic [7:0] dt, input logic st, input logic pst, input logic kd,
                     input logic te, input logic bz, input logic pbz);
    int  kind;
    ev_t e;
    bit  bad;
    if (we)              kind = K_WR;
    else if (st && !pst) kind = K_ST;
    else if (kd)         kind = K_KD;
    else if (pst && !st) kind = K_TO;
    else if (pbz && !bz) kind = K_ID;
    else return;
    checks++;
    if ((d == 0 && ev0.size() == 0) || (d == 1 && ev2.size() == 0)) begin
      errors++;
      $display("FAIL event_dut%0d: got unexpected kind %0d at cycle %0d, required no event", d, kind, c);
      return;
    end
    e = (d == 0) ? ev0.pop_front() : ev2.pop_front();
    bad = (e.kind != kind) || (e.cyc != c) ||
          (kind == K_WR && (e.a != a || e.d != dt)) ||
          (kind == K_TO && (te !== 1'b1 || bz !== 1'b0));
    if (bad) begin
      errors++;
      $display("FAIL event_dut%0d: got kind %0d cyc %0d addr %0h data %0h terr %0b, required kind %0d cyc %0d addr %0h data %0h",
               d, kind, c, a, dt, te, e.kind, e.cyc, e.a, e.d);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, cyc, if0.dcr_write_enable, if0.dcr_address, if0.dcr_data_out, if0.start, pst0,
          if0.kernel_done, if0.timeout_err, if0.busy, pb0);
      mon(1, cyc, if2.dcr_write_enable, if2.dcr_address, if2.dcr_data_out, if2.start, pst1,
          if2.kernel_done, if2.timeout_err, if2.busy, pb1);
    end
    pst0 = if0.start; pb0 = if0.busy;
    pst1 = if2.start; pb1 = if2.busy;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic stage_add(input logic [3:0] a, input logic [7:0] d);
    ent_t e;
    e.a = a; e.d = d;
    stage.push_back(e);
  endtask

  task automatic chk_ready();
    chk("cfg_ready_dut0", int'(if0.cfg_ready), int'(pend.size() < 8));
    chk("cfg_ready_dut2", int'(if2.cfg_ready), int'(pend.size() < 8));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dut0"}, int'({if0.dcr_write_enable, if0.dcr_address, if0.dcr_data_out, if0.start,
        if0.kernel_done, if0.timeout_err, if0.busy, if0.fifo_count, if0.cfg_ready}), 1);
    chk({tag, "_dut2"}, int'({if2.dcr_write_enable, if2.dcr_address, if2.dcr_data_out, if2.start,
        if2.kernel_done, if2.timeout_err, if2.busy, if2.fifo_count, if2.cfg_ready}), 1);
  endtask

  task automatic push_one(input ent_t e);
    chk_ready();
    cfg_valid = 1'b1; cfg_addr = e.a; cfg_data = e.d;
    if (pend.size() < 8) pend.push_back(e);
    step();
    cfg_valid = 1'b0;
    chk("fifo_count_dut0", int'(if0.fifo_count), pend.size());
    chk("fifo_count_dut2", int'(if2.fifo_count), pend.size());
  endtask

  // Pushes the staged entries (last one together with launch when same=1),
  // launches, raises done dly cycles after the launch cycle, waits for both idle.
  task automatic run_txn(input bit same, input int dly);
    int   n, dc, nst;
    bit   ok;
    ent_t e;
    nst = stage.size();
    for (int i = 0; i < nst - ((same && nst > 0) ? 1 : 0); i++) begin
      push_one(stage[i]);
      if ($urandom_range(0, 2) == 0) step();
    end
    n = cyc; dc = n + dly;
    if (same && nst > 0) begin
      e = stage[nst - 1];
      chk_ready();
      cfg_valid = 1'b1; cfg_addr = e.a; cfg_data = e.d;
      if (pend.size() < 8) pend.push_back(e);
    end
    launch = 1'b1; done = (dly == 0);
    plan(0, 0, n, dc); plan(1, 2, n, dc);
    pend.delete(); stage.delete();
    step();
    launch = 1'b0; cfg_valid = 1'b0; done = (cyc >= dc);
    chk("busy_after_launch_dut0", int'(if0.busy), 1);
    chk("busy_after_launch_dut2", int'(if2.busy), 1);
    chk("terr_after_launch_dut0", int'(if0.timeout_err), 0);
    chk("terr_after_launch_dut2", int'(if2.timeout_err), 0);
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (!if0.busy && !if2.busy && ev0.size() == 0 && ev2.size() == 0) begin
        ok = 1'b1;
        break;
      end
      step();
      done = (cyc >= dc);
      if (cyc == n + 110 && dc > n + 115) begin
        chk("start_held_dut0", int'(if0.start), TO_EN ? 0 : 1);
        chk("start_held_dut2", int'(if2.start), TO_EN ? 0 : 1);
      end
    end
    chk("txn_complete_in_budget", int'(ok), 1);
    chk("fifo_empty_dut0", int'(if0.fifo_count), 0);
    chk("fifo_empty_dut2", int'(if2.fifo_count), 0);
    done = 1'b0;
    if (!ok) begin ev0.delete(); ev2.delete(); end
    step();
  endtask

  task automatic reset_mid_write();
    int n;
    for (int i = 0; i < 8; i++) stage_add(4'(i), 8'($urandom));
    for (int i = 0; i < 8; i++) push_one(stage[i]);
    stage.delete();
    n = cyc;
    launch = 1'b1;
    plan(0, 0, n, n + 1000); plan(1, 2, n, n + 1000);
    pend.delete();
    step();
    launch = 1'b0;
    repeat (4) step();
    chk("mid_write_fifo_count", int'(if0.fifo_count), 4);
    chk("mid_write_we", int'(if0.dcr_write_enable), 1);
    rst_n = 1'b0;
    #1;
    chk_reset("async_reset");
    ev0.delete(); ev2.delete();
    step();
    chk_reset("reset_held_mid");
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset_held");
    rst_n = 1'b1;
    step();
    chk_reset("after_release");

    stage_add(4'h1, 8'hAA);
    run_txn(1'b0, 6);

    for (int i = 0; i < 9; i++) stage_add(4'(i % 8), 8'($urandom));
    run_txn(1'b0, 3);

    for (int i = 0; i < 3; i++) stage_add(4'($urandom), 8'($urandom));
    run_txn(1'b0, 2);

    run_txn(1'b0, 0);

    stage_add(4'hC, 8'h5A);
    run_txn(1'b1, 4);

    reset_mid_write();
    stage_add(4'h3, 8'h3C);
    run_txn(1'b1, 5);

    run_txn(1'b0, 150);

    for (int t = 0; t < 25; t++) begin
      int k;
      k = $urandom_range(0, 9);
      for (int i = 0; i < k; i++) stage_add(4'($urandom), 8'($urandom));
      run_txn(1'($urandom_range(0, 1)), $urandom_range(0, 30));
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit: got cycle %0d, required finish before limit", cyc);
    $fatal(1, "time limit");
  end
endmodule
